// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM state encoding and round helper functions.
// Latency: n/a (pure combinational helpers). Backpressure: n/a.
// Shared by the engine top and the message scheduler.
package sha256_pkg;

    typedef enum logic [2:0] {
        LOAD,
        ROUND,
        ADD,
        SHIFT,
        DONE
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] H0 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] S0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic logic [31:0] S1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] Ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] Maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: 16-word sliding window, head word is Wt for the current round.
// Latency: Wt valid the cycle after load, advances one word per shift.
// Backpressure: none; advances only when the engine asserts shift.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] message,
    output logic [31:0]  wt
);

    logic [31:0] w [0:15];
    logic [31:0] w_new;

    // Window holds W[t..t+15]; the tail refill is W[t+16] built from the same window.
    assign w_new = s1(w[14]) + w[9] + s0(w[1]) + w[0];
    assign wt    = w[0];

    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) begin
                w[i] <= message[511 - 32*i -: 32];
            end
        end else if (shift) begin
            for (int i = 0; i < 15; i++) begin
                w[i] <= w[i+1];
            end
            w[15] <= w_new;
        end
    end

endmodule

// File: rtl/sha.sv
// Single-block SHA-256 engine; digest streamed serially MSB first on hashout.
// Latency: 1 load + 64 rounds + 1 add, then 256 serial bits (last bit after edge 321).
// Backpressure: none; runs to DONE and holds until rst.
module sha
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] message,
    output logic         hashout
);

    state_t       state_q, state_d;
    logic [5:0]   round_q;
    logic [7:0]   bitcnt_q;
    logic [31:0]  a, b, c, d, e, f, g, h;
    logic [31:0]  wt, t1, t2;
    logic [255:0] digest;
    logic [255:0] shreg;

    sha256_msg_sched u_sched (
        .clk     (clk),
        .load    (state_q == LOAD && !rst),
        .shift   (state_q == ROUND),
        .message (message),
        .wt      (wt)
    );

    assign t1 = h + S1(e) + Ch(e, f, g) + K[round_q] + wt;
    assign t2 = S0(a) + Maj(a, b, c);

    assign digest = {H0[0] + a, H0[1] + b, H0[2] + c, H0[3] + d,
                     H0[4] + e, H0[5] + f, H0[6] + g, H0[7] + h};

    // Output is the top bit of the shift register, so it is a flop with no extra stage.
    assign hashout = shreg[255];

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    state_d = ROUND;
            ROUND:   if (round_q == 6'd63) state_d = ADD;
            ADD:     state_d = SHIFT;
            SHIFT:   if (bitcnt_q == 8'd254) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOAD;
            round_q  <= '0;
            bitcnt_q <= '0;
            shreg    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                LOAD: begin
                    round_q <= '0;
                    {a, b, c, d} <= {H0[0], H0[1], H0[2], H0[3]};
                    {e, f, g, h} <= {H0[4], H0[5], H0[6], H0[7]};
                    shreg <= '0;
                end
                ROUND: begin
                    round_q <= round_q + 6'd1;
                    h <= g;
                    g <= f;
                    f <= e;
                    e <= d + t1;
                    d <= c;
                    c <= b;
                    b <= a;
                    a <= t1 + t2;
                end
                ADD: begin
                    shreg    <= digest;
                    bitcnt_q <= '0;
                end
                SHIFT: begin
                    shreg    <= {shreg[254:0], 1'b0};
                    bitcnt_q <= bitcnt_q + 8'd1;
                end
                default: shreg <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sha.sv
// Directed bench for the serial SHA-256 engine: known digests, reset behaviour, message isolation.
module tb_sha;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] message;
    logic         hashout;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIGEST =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic [511:0] abc_msg;
    logic [511:0] empty_msg;

    sha dut (
        .clk     (clk),
        .rst     (rst),
        .message (message),
        .hashout (hashout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
        end
    endtask

    // Runs edges 1..last_edge of one hash; rst must already be low.
    task automatic run_block(input logic [255:0] exp, input string tag,
                             input bit perturb, input int last_edge);
        logic [255:0] stream;
        stream = '0;
        for (int ed = 1; ed <= last_edge; ed++) begin
            step();
            if (perturb && ed == 1) begin
                for (int wd = 0; wd < 16; wd++) begin
                    message[32*wd +: 32] = $urandom;
                end
            end
            if (ed <= 65) begin
                chk({tag, "_quiet"}, ed, hashout, 1'b0);
            end else if (ed <= 321) begin
                stream[255 - (ed - 66)] = hashout;
                chk({tag, "_bit"}, ed - 66, hashout, exp[255 - (ed - 66)]);
            end else begin
                chk({tag, "_done"}, ed, hashout, 1'b0);
            end
        end
        if (last_edge >= 321) begin
            vectors++;
            assert (stream === exp) else begin
                miscompares++;
                $error("FAIL %s_digest observed=%h expected=%h", tag, stream, exp);
            end
        end
    endtask

    initial begin
        abc_msg = '0;
        abc_msg[511:480] = 32'h61626380;
        abc_msg[31:0]    = 32'h00000018;
        empty_msg = '0;
        empty_msg[511:480] = 32'h80000000;

        // Reset state
        rst = 1'b1;
        message = abc_msg;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset", i, hashout, 1'b0);
        end
        rst = 1'b0;

        // "abc" digest, then DONE must stay quiet for 60 cycles
        run_block(ABC_DIGEST, "abc", 1'b0, 381);

        // Long reset: no advance while held
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst_hold", i, hashout, 1'b0);
        end
        rst = 1'b0;
        message = empty_msg;
        run_block(EMPTY_DIGEST, "empty", 1'b0, 330);

        // Message changed after load must not affect the digest
        rst = 1'b1;
        message = abc_msg;
        step();
        rst = 1'b0;
        run_block(ABC_DIGEST, "isolate", 1'b1, 325);

        // One-cycle reset mid-shift aborts, then a clean restart streams the digest again
        rst = 1'b1;
        message = abc_msg;
        step();
        rst = 1'b0;
        run_block(ABC_DIGEST, "pre_abort", 1'b0, 150);
        rst = 1'b1;
        step();
        chk("abort", 0, hashout, 1'b0);
        rst = 1'b0;
        run_block(ABC_DIGEST, "restart", 1'b0, 330);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
